// File: rtl/ddr2_avalon_local_bridge.sv
// Avalon-MM slave front end driving the DDR2 half-rate controller local_* interface.
// Sticky status flags are built only when DDR2_BRIDGE_STATUS_EN is defined.
module ddr2_avalon_local_bridge #(
    parameter int unsigned ADDR_W    = 23,
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned BE_W      = 8,
    parameter int unsigned CMD_DEPTH = 4,
    parameter int unsigned WD_DEPTH  = 4,
    parameter int unsigned MAX_RD    = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [DATA_W-1:0] avs_writedata,
    input  logic [BE_W-1:0]   avs_byteenable,
    output logic              avs_waitrequest,
    output logic [DATA_W-1:0] avs_readdata,
    output logic              avs_readdatavalid,
    input  logic              local_init_done,
    input  logic              local_ready,
    output logic [ADDR_W-1:0] local_address,
    output logic              local_read_req,
    output logic              local_write_req,
    output logic              local_burstbegin,
    output logic              local_size,
    input  logic              local_wdata_req,
    output logic [DATA_W-1:0] local_wdata,
    output logic [BE_W-1:0]   local_be,
    input  logic [DATA_W-1:0] local_rdata,
    input  logic              local_rdata_valid,
    input  logic              local_rdata_error,
    output logic [7:0]        rd_outstanding,
    output logic [2:0]        err_flags
);
    localparam int unsigned CA_W = $clog2(CMD_DEPTH);
    localparam int unsigned WA_W = $clog2(WD_DEPTH);

    typedef logic [CA_W-1:0] cptr_t;
    typedef logic [CA_W:0]   ccnt_t;
    typedef logic [WA_W-1:0] wptr_t;
    typedef logic [WA_W:0]   wcnt_t;
    typedef enum logic {IDLE, REQ} state_t;

    state_t                   state;
    logic                     init_q;
    logic [ADDR_W:0]          cmd_mem [CMD_DEPTH];
    cptr_t                    cmd_rd, cmd_wr, cmd_rd_next;
    ccnt_t                    cmd_cnt, cmd_left;
    logic [DATA_W+BE_W-1:0]   wd_mem [WD_DEPTH];
    wptr_t                    wd_rd, wd_wr;
    wcnt_t                    wd_cnt;
    logic [7:0]               rd_cnt;
    logic                     cmd_full, wd_full, rd_full, accept;
    logic                     cmd_push, cmd_pop, wd_push, wd_pop, rd_inc, rd_ret;
    logic [ADDR_W:0]          head_next;

    always_comb begin
        cmd_full        = (cmd_cnt == ccnt_t'(CMD_DEPTH));
        wd_full         = (wd_cnt == wcnt_t'(WD_DEPTH));
        rd_full         = (rd_cnt == 8'(MAX_RD));
        avs_waitrequest = !init_q || cmd_full || (avs_write && wd_full) || (avs_read && rd_full);
        accept          = !avs_waitrequest && (avs_read || avs_write);
        cmd_push        = accept;
        wd_push         = accept && avs_write;
        rd_inc          = accept && !avs_write;
        cmd_pop         = (state == REQ) && local_ready;
        wd_pop          = local_wdata_req && (wd_cnt != '0);
        rd_ret          = local_rdata_valid && (rd_cnt != '0);
        cmd_left        = cmd_pop ? cmd_cnt - ccnt_t'(1) : cmd_cnt;
        cmd_rd_next     = cmd_pop ? cmd_rd + cptr_t'(1) : cmd_rd;
        // When nothing else remains queued, the entry being pushed right now is
        // the next head; bypassing it gives single-cycle issue latency.
        head_next       = (cmd_left == '0) ? {avs_write, avs_address} : cmd_mem[cmd_rd_next];
        {local_wdata, local_be} = wd_mem[wd_rd];
        local_size      = 1'b1;
        rd_outstanding  = rd_cnt;
    end

    always_ff @(posedge clk) begin
        if (cmd_push) cmd_mem[cmd_wr] <= {avs_write, avs_address};
        if (wd_push)  wd_mem[wd_wr]   <= {avs_writedata, avs_byteenable};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            init_q  <= 1'b0;
            cmd_rd  <= '0;
            cmd_wr  <= '0;
            cmd_cnt <= '0;
            wd_rd   <= '0;
            wd_wr   <= '0;
            wd_cnt  <= '0;
            rd_cnt  <= '0;
        end else begin
            init_q  <= local_init_done;
            cmd_rd  <= cmd_rd_next;
            cmd_cnt <= cmd_left + ccnt_t'(cmd_push);
            if (cmd_push) cmd_wr <= cmd_wr + cptr_t'(1);
            if (wd_push)  wd_wr  <= wd_wr + wptr_t'(1);
            if (wd_pop)   wd_rd  <= wd_rd + wptr_t'(1);
            wd_cnt  <= wd_cnt + wcnt_t'(wd_push) - wcnt_t'(wd_pop);
            rd_cnt  <= rd_cnt + 8'(rd_inc) - 8'(rd_ret);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            avs_readdatavalid <= 1'b0;
            avs_readdata      <= '0;
        end else begin
            avs_readdatavalid <= rd_ret;
            if (rd_ret) avs_readdata <= local_rdata;
        end
    end

    // Issue FSM: burstbegin marks only the first cycle a command is presented.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            local_read_req   <= 1'b0;
            local_write_req  <= 1'b0;
            local_burstbegin <= 1'b0;
            local_address    <= '0;
        end else if (state == IDLE || cmd_pop) begin
            if (cmd_left != '0 || cmd_push) begin
                state            <= REQ;
                local_write_req  <= head_next[ADDR_W];
                local_read_req   <= !head_next[ADDR_W];
                local_address    <= head_next[ADDR_W-1:0];
                local_burstbegin <= 1'b1;
            end else begin
                state            <= IDLE;
                local_write_req  <= 1'b0;
                local_read_req   <= 1'b0;
                local_burstbegin <= 1'b0;
            end
        end else begin
            local_burstbegin <= 1'b0;
        end
    end

`ifdef DDR2_BRIDGE_STATUS_EN
    logic [2:0] flags;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags <= '0;
        end else begin
            if (local_wdata_req && wd_cnt == '0)      flags[2] <= 1'b1;
            if (local_rdata_valid && rd_cnt == '0)    flags[1] <= 1'b1;
            if (local_rdata_valid && local_rdata_error) flags[0] <= 1'b1;
        end
    end

    assign err_flags = flags;
`else
    logic unused_status;

    assign unused_status = local_rdata_error;
    assign err_flags     = '0;
`endif

endmodule

// File: doc/ddr2_avalon_local_bridge.md
# ddr2_avalon_local_bridge

Avalon-MM slave front end for the DDR2 half-rate controller's native local interface; sits directly upstream of the controller/PHY top and drives its `local_*` request, write-data and read-return ports. Buffers commands and write data in small FIFOs and converts the controller's `local_ready` / `local_wdata_req` handshakes into Avalon `waitrequest`. It tracks outstanding reads so that the number in flight never exceeds a fixed bound, and returns read data in order with a registered `readdatavalid`.

## Interface
Parameters:
- `ADDR_W`, 23: local word address width (bank, row and column).
- `DATA_W`, 64: half-rate local data width.
- `BE_W`, 8: byte enables, `DATA_W/8`.
- `CMD_DEPTH`, 4: command FIFO depth; power of 2, at least 2.
- `WD_DEPTH`, 4: write-data FIFO depth; power of 2, at least `CMD_DEPTH`.
- `MAX_RD`, 8: maximum outstanding reads, in the range 1..255.

Ports:
- `clk`  in  1: controller clock (`phy_clk`). Single clock domain.
- `reset_n`  in  1: asynchronous assert, active-low reset.
- `avs_address`  in  ADDR_W: word address.
- `avs_read`, `avs_write`  in  1: commands. Asserting both together is illegal and is treated as a write.
- `avs_writedata`  in  DATA_W.
- `avs_byteenable`  in  BE_W.
- `avs_waitrequest`  out  1: stall.
- `avs_readdata`  out  DATA_W.
- `avs_readdatavalid`  out  1.
- `local_init_done`  in  1: calibration/init complete.
- `local_ready`  in  1: controller accepts the presented request.
- `local_address`  out  ADDR_W.
- `local_read_req`, `local_write_req`  out  1.
- `local_burstbegin`  out  1.
- `local_size`  out  1: constant 1.
- `local_wdata_req`  in  1: controller consumes write data this cycle.
- `local_wdata`  out  DATA_W.
- `local_be`  out  BE_W.
- `local_rdata`  in  DATA_W.
- `local_rdata_valid`  in  1.
- `local_rdata_error`  in  1.
- `rd_outstanding`  out  8: current in-flight read count.
- `err_flags`  out  3: sticky status bits {underrun, unsolicited, rdata_error}.

## Operation
- Accept condition: `avs_waitrequest` is low and `avs_read` or `avs_write` is high.
- `avs_waitrequest` = `!init_q` | cmd_full | (`avs_write` & wd_full) | (`avs_read` & `rd_outstanding`==MAX_RD). It is combinational from registers and inputs. `init_q` is `local_init_done` registered once.
- Write accept: push {1, address} into the command FIFO and {writedata, byteenable} into the write-data FIFO in the same cycle.
- Read accept: push {0, address} into the command FIFO and increment `rd_outstanding`.
- Issue FSM states:
  - IDLE: when the command FIFO is non-empty, go to REQ.
  - REQ: drive the head entry on `local_*_req`/`local_address`.
    - If `local_ready` is high, pop the head. Go to REQ if the FIFO is still non-empty, otherwise go to IDLE.
    - If `local_ready` is low, hold REQ with the request and address stable.
- `local_burstbegin` is high only in the first REQ cycle of each command, not while the request is held waiting for `local_ready`.
- Write data path:
  - `local_wdata`/`local_be` always show the write-data FIFO head.
  - The head is popped on `local_wdata_req`.
  - `local_wdata_req` while the FIFO is empty: nothing is popped and the underrun flag is set.
- Read return:
  - `local_rdata_valid` with `rd_outstanding`>0: decrement the count and forward the data.
  - `local_rdata_valid` with `rd_outstanding`==0: the beat is dropped, no `readdatavalid` is generated, and the unsolicited flag is set.
  - A read accept and a return in the same cycle leave the count unchanged.
- `local_rdata_error` together with `local_rdata_valid` sets the rdata_error flag; the data is still forwarded.
- `err_flags` clear only on reset.

## Timing
- Reset values:
  - `avs_waitrequest`=1 and `avs_readdatavalid`=0.
  - `avs_readdata`=0.
  - `local_read_req`, `local_write_req` and `local_burstbegin` = 0.
  - `local_address`=0.
  - `rd_outstanding`=0 and `err_flags`=0.
  - FIFOs empty; FSM in IDLE.
- Command accepted at edge N: `local_*_req` is asserted in cycle N+1, which is the minimum latency.
- Back-to-back: with `local_ready` held high, one command issues per cycle.
- `local_rdata_valid` in cycle M: `avs_readdatavalid`/`avs_readdata` are registered and appear in cycle M+1.
- FIFO full: the accept is blocked in the same cycle. A pop and a push in the same cycle on a full FIFO is still blocked, because full is evaluated from registered state.
- Reset asserted mid-request: outputs drop immediately (asynchronous) and all queued or in-flight state is discarded.
- `local_init_done` falling after init: no new accepts. Queued commands keep issuing, because the controller owns `local_ready`.

## Configuration
- `DDR2_BRIDGE_STATUS_EN`:
  - Defined: the three sticky flags are implemented as described above.
  - Undefined: `err_flags` is tied to 0 and the flag logic is removed. Underrun and unsolicited beats are still dropped or ignored in the same way.

## Test plan
- Write at 0x000010 with data 0xDEADBEEF_01234567 and BE 0xFF, `local_ready`=1: `local_write_req` and `local_burstbegin` rise 1 cycle later with address 0x000010. On the next `local_wdata_req`, `local_wdata` shows the same data.
- `local_ready` held low for 3 cycles during a read: `local_read_req` is held for 4 cycles and `local_burstbegin` pulses only in the first of them.
- 8 reads with no return (MAX_RD=8): a 9th read sees `avs_waitrequest`=1. One `local_rdata_valid` then drops `rd_outstanding` to 7 and the 9th read is accepted.
- Read return 0xA5A5… at cycle M: `avs_readdatavalid`=1 with 0xA5A5… at M+1. A simultaneous new read accept leaves `rd_outstanding` unchanged.
- `local_rdata_valid` with `rd_outstanding`=0, then `local_wdata_req` with the write-data FIFO empty: no `readdatavalid`, and `err_flags`=3'b110 when the macro is defined, 0 when it is not.
- Reset pulse while 3 commands are queued: all outputs return to their reset values immediately, and no request is issued after reset until new accepts arrive.
